mix8_unmix: RTL and testbench
=============================

# mix8_unmix

Iterative inverse of the 8×32-bit ARX mixing round used by the state-mixing datapath. It accepts one 256-bit mixed state over a valid/ready handshake and undoes `ROUNDS` forward rounds, one word operation per clock. It then presents the recovered pre-mix state over a second valid/ready handshake. It sits downstream of the mixer as its decoder and restores original operands for checking and replay.

## Interface
- `ROUNDS`, default 4: number of forward rounds to undo. Legal range is 1–16.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: mixed state offered.
- `in_ready`  out  1: block can accept a state.
- `in_data`  in  256: mixed state; word i occupies bits [32i+31:32i].
- `out_valid`  out  1: recovered state available.
- `out_ready`  in  1: consumer accepts the recovered state.
- `out_data`  out  256: recovered state, same packing as `in_data`.
- `busy`  out  1: high in UNXOR or UNADD.
- `blk_cnt`  out  32: count of completed output handshakes. Present only with `MIX8_UNMIX_CNT_EN`.

## Operation
- All arithmetic is modulo 2^32.
- Forward round, defined here as the contract:
  - Step A, for i = 0..7 in order, in place: w[i] = w[i] + w[(i+7)%8].
  - Step B, for i = 0..7 in order, in place: w[i] = w[i] ^ (w[(i+3)%8] << 16).
  - The shift truncates to 32 bits.
- Inverse round:
  - UNXOR, for i = 7 down to 0, in place: w[i] ^= w[(i+3)%8] << 16.
  - Then UNADD, for i = 7 down to 0, in place: w[i] -= w[(i+7)%8].
  - Exact inversion holds because every index above i is already restored and every index below i still holds its forward value.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, load `in_data` into state register, set idx=7 and rnd=0, go to UNXOR.
  - UNXOR: one word per cycle at idx. When idx==0, set idx=7 and go to UNADD; otherwise decrement idx.
  - UNADD: one word per cycle at idx. When idx==0, go to DONE if rnd==ROUNDS-1; otherwise increment rnd, set idx=7, and go to UNXOR.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- `out_data` is the state register, driven directly. It is stable throughout DONE.
- `in_data` is ignored outside IDLE.
- `out_ready` is ignored outside DONE.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, `blk_cnt`=0.
  - FSM=IDLE, idx=7, rnd=0.
- Input handshake on edge N: first word operation at edge N+1. `out_valid` rises after edge N+16·ROUNDS, so latency is 16·ROUNDS cycles.
- `out_valid` stays high until `out_ready` is sampled high. `in_ready` rises the cycle after the output handshake.
- No overlap: the next input is accepted no earlier than one cycle after the output handshake.
- Throughput: one state per 16·ROUNDS+2 cycles with `out_ready` tied high.
- Reset asserted mid-operation aborts the operation immediately. All outputs return to their reset values, and the partial result is discarded.
- `in_valid` held high while the block is busy has no effect. The input is accepted on the first IDLE cycle.

## Configuration
- `MIX8_UNMIX_CNT_EN` defined:
  - `blk_cnt` port exists.
  - It increments by 1 on each `out_valid`&&`out_ready` edge.
  - It wraps from 0xFFFFFFFF to 0 silently.
- `MIX8_UNMIX_CNT_EN` undefined: the port and the counter register are absent. All other behaviour is identical.

## Structure
- Package `mix8_pkg` holds:
  - `MIX8_WORDS`=8, `MIX8_XOR_TAP`=3, `MIX8_XOR_SHIFT`=16, `MIX8_ADD_TAP`=7.
  - `mix8_state_t`, an array of eight 32-bit words.
  - FSM enum `mix8_unmix_st_e` with values IDLE, UNXOR, UNADD, DONE.
- One sub-module, `mix8_unmix_step`, is combinational.
  - Inputs: state, idx, op (xor or sub).
  - Output: the updated word for idx.
  - The top block holds the FSM, counters and state register.

## Test plan
- ROUNDS=1, `in_data` = all words 0x00010001 → `out_data` word0=1, words1–7=0. `out_valid` rises exactly 16 cycles after the input handshake.
- ROUNDS=4, all-zero input → all-zero output.
- ROUNDS=4, random inputs:
  - Drive 1000 states through a bench reference model of the forward round.
  - Feed each mixed state into the block.
  - Every `out_data` must equal the original pre-mix state.
- Backpressure: hold `out_ready`=0 for 50 cycles after `out_valid`.
  - `out_data` must stay stable and `in_ready` must stay 0 during that time.
  - The next input is accepted one cycle after `out_ready` rises.
- Reset mid-UNADD with ROUNDS=2 → next cycle `busy`=0, `in_ready`=1, `out_data`=0. A subsequent input decodes correctly.
- `MIX8_UNMIX_CNT_EN` defined:
  - Three output handshakes → `blk_cnt`=3.
  - Force the counter to 0xFFFFFFFF, then one handshake → `blk_cnt`=0.

Source files
------------

// File: rtl/mix8_pkg.sv
// mix8_pkg: shared constants and types for the 8x32-bit ARX unmix datapath.
//   MIX8_WORDS / taps / shift : geometry of the forward mixing round
//   mix8_state_t              : eight 32-bit words, word i at bits [32i+31:32i]
//   mix8_unmix_st_e           : FSM states of mix8_unmix
//   mix8_op_e                 : word operation selected for mix8_unmix_step
package mix8_pkg;

    localparam int MIX8_WORDS     = 8;
    localparam int MIX8_XOR_TAP   = 3;
    localparam int MIX8_XOR_SHIFT = 16;
    localparam int MIX8_ADD_TAP   = 7;

    typedef logic [31:0] mix8_word_t;
    typedef mix8_word_t [MIX8_WORDS-1:0] mix8_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UNXOR = 2'd1,
        UNADD = 2'd2,
        DONE  = 2'd3
    } mix8_unmix_st_e;

    typedef enum logic {
        OP_XOR = 1'b0,
        OP_SUB = 1'b1
    } mix8_op_e;

endpackage

// File: rtl/mix8_unmix_step.sv
// mix8_unmix_step: combinational single-word inverse operation.
//   state : full 8-word state register
//   idx   : word being restored
//   op    : OP_XOR undoes the shifted-xor step, OP_SUB undoes the add step
//   word  : new value for state[idx]
module mix8_unmix_step
    import mix8_pkg::*;
(
    input  mix8_state_t state,
    input  logic [2:0]  idx,
    input  mix8_op_e    op,
    output mix8_word_t  word
);

    // 3-bit adds wrap naturally, giving the (i+tap)%8 neighbours.
    logic [2:0] xor_idx;
    logic [2:0] add_idx;

    assign xor_idx = idx + 3'(MIX8_XOR_TAP);
    assign add_idx = idx + 3'(MIX8_ADD_TAP);

    always_comb begin
        word = state[idx];
        case (op)
            OP_XOR:  word = state[idx] ^ (state[xor_idx] << MIX8_XOR_SHIFT);
            OP_SUB:  word = state[idx] - state[add_idx];
            default: word = state[idx];
        endcase
    end

endmodule

// File: rtl/mix8_unmix.sv
// mix8_unmix: iterative inverse of ROUNDS forward 8x32 ARX mixing rounds.
// One word is restored per clock, so a state takes 16*ROUNDS cycles.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : mixed state handshake, in_data (256 bits)
//   out_valid/out_ready  : recovered state handshake, out_data (256 bits)
//   busy                 : high while unmixing (UNXOR or UNADD)
//   blk_cnt              : completed output handshakes, only when
//                          MIX8_UNMIX_CNT_EN is defined
module mix8_unmix
    import mix8_pkg::*;
#(
    parameter int ROUNDS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_data,
    output logic         busy
`ifdef MIX8_UNMIX_CNT_EN
    ,
    output logic [31:0]  blk_cnt
`endif
);

    mix8_unmix_st_e st_q, st_n;
    logic [2:0]     idx_q, idx_n;
    logic [3:0]     rnd_q, rnd_n;
    mix8_state_t    data_q, data_n;
    mix8_op_e       op;
    mix8_word_t     step_word;

    mix8_unmix_step u_step (
        .state (data_q),
        .idx   (idx_q),
        .op    (op),
        .word  (step_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            idx_q  <= 3'd7;
            rnd_q  <= 4'd0;
            data_q <= '0;
        end else begin
            st_q   <= st_n;
            idx_q  <= idx_n;
            rnd_q  <= rnd_n;
            data_q <= data_n;
        end
    end

    // Each inverse pass walks idx from 7 down to 0: higher words are already
    // restored and lower words still hold their forward value.
    always_comb begin
        st_n   = st_q;
        idx_n  = idx_q;
        rnd_n  = rnd_q;
        data_n = data_q;
        op     = OP_XOR;
        case (st_q)
            IDLE: begin
                if (in_valid) begin
                    data_n = in_data;
                    idx_n  = 3'd7;
                    rnd_n  = 4'd0;
                    st_n   = UNXOR;
                end
            end
            UNXOR: begin
                op             = OP_XOR;
                data_n[idx_q]  = step_word;
                if (idx_q == 3'd0) begin
                    idx_n = 3'd7;
                    st_n  = UNADD;
                end else begin
                    idx_n = idx_q - 3'd1;
                end
            end
            UNADD: begin
                op             = OP_SUB;
                data_n[idx_q]  = step_word;
                if (idx_q == 3'd0) begin
                    if (rnd_q == 4'(ROUNDS - 1)) begin
                        st_n = DONE;
                    end else begin
                        rnd_n = rnd_q + 4'd1;
                        idx_n = 3'd7;
                        st_n  = UNXOR;
                    end
                end else begin
                    idx_n = idx_q - 3'd1;
                end
            end
            DONE: begin
                if (out_ready) st_n = IDLE;
            end
            default: st_n = IDLE;
        endcase
    end

    assign in_ready  = (st_q == IDLE);
    assign out_valid = (st_q == DONE);
    assign busy      = (st_q == UNXOR) || (st_q == UNADD);
    assign out_data  = data_q;

`ifdef MIX8_UNMIX_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        blk_cnt <= 32'd0;
        else if (out_valid && out_ready)   blk_cnt <= blk_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mix8_unmix.sv
// tb_mix8_unmix: three instances (ROUNDS = 1, 2, 4) driven by directed
// vectors; a cycle-level behavioural model checks every output each cycle.
module tb_mix8_unmix;

    logic         clk = 1'b0;
    logic [2:0]   rst_n;
    logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
    logic [255:0] in_data  [3];
    logic [255:0] out_data [3];
`ifdef MIX8_UNMIX_CNT_EN
    logic [31:0]  blk_cnt  [3];
`endif

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    function automatic int rounds_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        mix8_unmix #(.ROUNDS((k == 0) ? 1 : (k == 1) ? 2 : 4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[k]),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .in_data   (in_data[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k]),
            .busy      (busy[k])
`ifdef MIX8_UNMIX_CNT_EN
            ,
            .blk_cnt   (blk_cnt[k])
`endif
        );
    end

    // ---------------- reference round functions ----------------
    function automatic logic [255:0] fwd(input logic [255:0] s, input int r);
        logic [31:0] w [8];
        logic [255:0] o;
        for (int i = 0; i < 8; i++) w[i] = s[32*i +: 32];
        for (int n = 0; n < r; n++) begin
            for (int i = 0; i < 8; i++) w[i] = w[i] + w[(i+7)%8];
            for (int i = 0; i < 8; i++) w[i] = w[i] ^ (w[(i+3)%8] << 16);
        end
        for (int i = 0; i < 8; i++) o[32*i +: 32] = w[i];
        return o;
    endfunction

    function automatic logic [255:0] unmix(input logic [255:0] s, input int r);
        logic [31:0] w [8];
        logic [255:0] o;
        for (int i = 0; i < 8; i++) w[i] = s[32*i +: 32];
        for (int n = 0; n < r; n++) begin
            for (int i = 7; i >= 0; i--) w[i] = w[i] ^ (w[(i+3)%8] << 16);
            for (int i = 7; i >= 0; i--) w[i] = w[i] - w[(i+7)%8];
        end
        for (int i = 0; i < 8; i++) o[32*i +: 32] = w[i];
        return o;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // ---------------- cycle model + compare process ----------------
    // phase: 0 idle, 1 unmixing (cnt cycles left), 2 result offered
    int           ph   [3];
    int           cnt  [3];
    logic [255:0] pend [3];
    logic [255:0] last [3];
    logic [31:0]  bc   [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n[k]) begin
                ph[k] = 0; cnt[k] = 0; last[k] = '0; bc[k] = 32'd0;
            end else begin
                case (ph[k])
                    0: if (in_valid[k]) begin
                        ph[k]   = 1;
                        cnt[k]  = 16 * rounds_of(k);
                        pend[k] = unmix(in_data[k], rounds_of(k));
                    end
                    1: begin
                        cnt[k]--;
                        if (cnt[k] == 0) begin
                            ph[k]   = 2;
                            last[k] = pend[k];
                        end
                    end
                    default: if (out_ready[k]) begin
                        ph[k] = 0;
                        bc[k] = bc[k] + 32'd1;
                    end
                endcase
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("in_ready[%0d]", k),  256'(in_ready[k]),  256'(ph[k] == 0));
            chk($sformatf("busy[%0d]", k),      256'(busy[k]),      256'(ph[k] == 1));
            chk($sformatf("out_valid[%0d]", k), 256'(out_valid[k]), 256'(ph[k] == 2));
            if (ph[k] != 1) chk($sformatf("out_data[%0d]", k), out_data[k], last[k]);
`ifdef MIX8_UNMIX_CNT_EN
            chk($sformatf("blk_cnt[%0d]", k), 256'(blk_cnt[k]), 256'(bc[k]));
`endif
        end
    end

    // ---------------- drivers ----------------
    task automatic start(input int k, input logic [255:0] data);
        int n = 0;
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_data[k]  = data;
        while (!in_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[k]) begin
            errs++;
            $display("FAIL accept_timeout[%0d] got=no_accept want=accept", k);
        end
        @(negedge clk);   // handshake happened on the posedge just passed
        in_valid[k] = 1'b0;
        in_data[k]  = {8{32'hDEAD_BEEF}};  // must be ignored while busy
    endtask

    // Entered at the negedge right after the input handshake edge.
    task automatic finish(input int k, input logic [255:0] orig, input int hold);
        int n = 0;
        int budget = 16 * rounds_of(k) + 10;
        while (!out_valid[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency[%0d]", k), 256'(n), 256'(16 * rounds_of(k)));
        chk($sformatf("roundtrip[%0d]", k), out_data[k], orig);
        for (int h = 0; h < hold; h++) @(negedge clk);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic run(input int k, input logic [255:0] orig, input int hold);
        start(k, fwd(orig, rounds_of(k)));
        finish(k, orig, hold);
    endtask

    logic [255:0] v, tmp;

    initial begin
        rst_n     = 3'b000;
        in_valid  = 3'b000;
        out_ready = 3'b000;
        for (int k = 0; k < 3; k++) in_data[k] = '0;
        repeat (2) @(negedge clk);
        rst_n = 3'b111;

        // hand-computed pins for the reference functions
        v = {8{32'h0001_0001}};
        chk("pin_unmix_r1", unmix(v, 1), 256'd1);
        chk("pin_fwd_r1", fwd(256'd1, 1), v);
        tmp = 256'd0;
        chk("pin_fwd_zero", fwd(tmp, 4), 256'd0);

        // ROUNDS=1 literal vector, latency 16
        start(0, v);
        finish(0, 256'd1, 0);

        // ROUNDS=4 all-zero
        run(2, 256'd0, 0);

        // backpressure 50 cycles, then next input one cycle after release
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run(2, v, 50);
        chk("in_ready_after_out", 256'(in_ready[2]), 256'd1);
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run(2, v, 0);

        // reset mid-UNADD on ROUNDS=2, then a clean decode
        v = {8{32'h1234_5678}};
        start(1, fwd(v, 2));
        repeat (10) @(negedge clk);       // inside first UNADD pass
        chk("busy_before_reset", 256'(busy[1]), 256'd1);
        rst_n[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        chk("out_data_after_reset", out_data[1], 256'd0);
        chk("in_ready_after_reset", 256'(in_ready[1]), 256'd1);
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run(1, v, 3);

`ifdef MIX8_UNMIX_CNT_EN
        chk("blk_cnt_one", 256'(blk_cnt[0]), 256'd1);
        run(0, 256'd7, 0);
        run(0, 256'd9, 2);
        chk("blk_cnt_three", 256'(blk_cnt[0]), 256'd3);
        @(negedge clk);
        force g_dut[0].u_dut.blk_cnt = 32'hFFFF_FFFF;
        #1;
        release g_dut[0].u_dut.blk_cnt;
        bc[0] = 32'hFFFF_FFFF;
        run(0, 256'd5, 0);
        chk("blk_cnt_wrap", 256'(blk_cnt[0]), 256'd0);
`endif

        // 1000 random states through ROUNDS=4
        for (int t = 0; t < 1000; t++) begin
            v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run(2, v, 0);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
